// File: rtl/aes_cipher_ctrl_if.sv
// Handshake and datapath bundle between the AES sequencing controller and its environment.
// slave = controller side; master = source/sink/datapath side.
interface aes_cipher_ctrl_if #(
  parameter int Nr    = 10,
  parameter int TAG_W = 8
);
  logic             key_ready;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_pt;
  logic [TAG_W-1:0] in_tag;
  logic [127:0]     cipher_pt;
  logic [0:Nr]      valid;
  logic [127:0]     cipher_ct;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_ct;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport slave (
    input  key_ready, in_valid, in_pt, in_tag, cipher_ct, out_ready,
    output in_ready, cipher_pt, valid, out_valid, out_ct, out_tag, busy
  );

  modport master (
    output key_ready, in_valid, in_pt, in_tag, cipher_ct, out_ready,
    input  in_ready, cipher_pt, valid, out_valid, out_ct, out_tag, busy
  );
endinterface

// File: rtl/aes_cipher_ctrl.sv
// AES pipeline sequencer: admits blocks on credits, drives stage enables, carries tags, buffers ciphertext.
// Accept-to-head latency Nr+2; admission stalls while pipeline plus FIFO already hold OUT_DEPTH blocks.
module aes_cipher_ctrl #(
  parameter int Nk        = 4,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_cipher_ctrl_if.slave bus
);
  localparam int Nr = Nk + 6;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [0:Nr]      r_occ;
  logic [TAG_W-1:0] r_tag [0:Nr];
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [127:0]     r_mem_ct  [OUT_DEPTH];
  logic [TAG_W-1:0] r_mem_tag [OUT_DEPTH];
  logic [127:0]     r_head_ct;
  logic [TAG_W-1:0] r_head_tag;

  logic             w_in_ready;
  logic             w_acc;
  logic [0:Nr]      w_valid;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_cnt_nxt;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;
  logic [127:0]     w_head_ct_nxt;
  logic [TAG_W-1:0] w_head_tag_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_in_ready     = rst_n && bus.key_ready && (r_outstanding < CW'(OUT_DEPTH));
    w_acc          = bus.in_valid && w_in_ready;
    w_valid        = {w_acc, r_occ[0:Nr-1]};
    w_push         = r_occ[Nr];
    w_pop          = (r_count != '0) && bus.out_ready;
    w_cnt_nxt      = r_count + CW'(w_push) - CW'(w_pop);
    w_wr_nxt       = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_nxt       = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_head_ct_nxt  = '0;
    w_head_tag_nxt = '0;
    // The new head is the block being written only when nothing older remains.
    if (w_cnt_nxt != '0) begin
      if (w_push && (w_rd_nxt == r_wr_ptr)) begin
        w_head_ct_nxt  = bus.cipher_ct;
        w_head_tag_nxt = r_tag[Nr];
      end else begin
        w_head_ct_nxt  = r_mem_ct[w_rd_nxt];
        w_head_tag_nxt = r_mem_tag[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
      for (int i = 0; i <= Nr; i++) r_tag[i] <= '0;
    end else begin
      r_occ <= w_valid;
      if (w_valid[0]) r_tag[0] <= bus.in_tag;
      for (int i = 1; i <= Nr; i++) begin
        if (w_valid[i]) r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ct[r_wr_ptr]  <= bus.cipher_ct;
      r_mem_tag[r_wr_ptr] <= r_tag[Nr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_head_ct     <= '0;
      r_head_tag    <= '0;
      r_outstanding <= '0;
    end else begin
      r_count    <= w_cnt_nxt;
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_head_ct  <= w_head_ct_nxt;
      r_head_tag <= w_head_tag_nxt;
      case ({w_acc, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.cipher_pt = bus.in_pt;
  assign bus.valid     = w_valid;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_ct    = r_head_ct;
  assign bus.out_tag   = r_head_tag;
  assign bus.busy      = (|r_occ) || (r_count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == CW'(OUT_DEPTH)) && !w_pop));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_outstanding <= CW'(OUT_DEPTH));
endmodule
